// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - register-file writeback arbiter bus bundle
interface wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            pipe_we_i;
    logic [4:0]      pipe_waddr_i;
    logic [XLEN-1:0] pipe_wdata_i;
    logic            lsu_valid_i;
    logic            lsu_ready_o;
    logic [4:0]      lsu_waddr_i;
    logic [XLEN-1:0] lsu_wdata_i;
    logic            stall_pipe_o;
    logic            rw_en_o;
    logic [4:0]      waddr_o;
    logic [XLEN-1:0] wdata_o;
    logic [4:0]      chk_addr_i;
    logic            chk_busy_o;

    modport slave (
        input  pipe_we_i, pipe_waddr_i, pipe_wdata_i,
        input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        input  chk_addr_i,
        output lsu_ready_o, stall_pipe_o, rw_en_o, waddr_o, wdata_o, chk_busy_o
    );

    modport master (
        output pipe_we_i, pipe_waddr_i, pipe_wdata_i,
        output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        output chk_addr_i,
        input  lsu_ready_o, stall_pipe_o, rw_en_o, waddr_o, wdata_o, chk_busy_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - pipeline / long-latency writeback arbiter with result buffer
module wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    wb_arbiter_if.slave bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

    // Buffer storage and bookkeeping
    logic [4:0]            mem_addr [FIFO_DEPTH];
    logic [XLEN-1:0]       mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] valid_q;
    logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]         count_q;
    logic [SW-1:0]         starve_q, starve_d;

    logic            stall_q, rw_en_q;
    logic [4:0]      waddr_q;
    logic [XLEN-1:0] wdata_q;

    logic lsu_ready, push, pop, sel_pipe, pipe_req, fifo_nonempty;

    // Ready is based on the registered count only, so a full buffer never
    // accepts a result even if it is being drained this very cycle.
    assign lsu_ready     = (count_q < DEPTH_C);
    assign fifo_nonempty = (count_q != '0);
    assign pipe_req      = bus.pipe_we_i && (bus.pipe_waddr_i != 5'd0);
    // Results for x0 are consumed but never stored.
    assign push          = bus.lsu_valid_i && lsu_ready && (bus.lsu_waddr_i != 5'd0);

    // Source selection: a starved buffer head beats the pipeline, otherwise pipeline first
    always_comb begin
        pop      = 1'b0;
        sel_pipe = 1'b0;
        if (stall_q && fifo_nonempty) begin
            pop = 1'b1;
        end else if (pipe_req) begin
            sel_pipe = 1'b1;
        end else if (fifo_nonempty) begin
            pop = 1'b1;
        end
    end

    // Starvation counter next value, saturating at the limit
    always_comb begin
        starve_d = starve_q;
        if (pop || !fifo_nonempty) begin
            starve_d = '0;
        end else if (starve_q != STARVE_C) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Register query: any live entry (including one popping now) targeting chk_addr_i
    always_comb begin
        bus.chk_busy_o = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (valid_q[i] && (mem_addr[i] == bus.chk_addr_i) && (bus.chk_addr_i != 5'd0)) begin
                bus.chk_busy_o = 1'b1;
            end
        end
    end

    // Buffer payload; contents are don't-care until marked valid
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= bus.lsu_waddr_i;
            mem_data[wr_ptr_q] <= bus.lsu_wdata_i;
        end
    end

    // Pointers, count, starvation tracking and registered write port
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            rw_en_q  <= 1'b0;
            waddr_q  <= 5'd0;
            wdata_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q          <= wr_ptr_q + PW'(1);
                valid_q[wr_ptr_q] <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q          <= rd_ptr_q + PW'(1);
                valid_q[rd_ptr_q] <= 1'b0;
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            starve_q <= starve_d;
            stall_q  <= (starve_d == STARVE_C);
            rw_en_q  <= sel_pipe || pop;
            if (sel_pipe) begin
                waddr_q <= bus.pipe_waddr_i;
                wdata_q <= bus.pipe_wdata_i;
            end else if (pop) begin
                waddr_q <= mem_addr[rd_ptr_q];
                wdata_q <= mem_data[rd_ptr_q];
            end
        end
    end

    assign bus.lsu_ready_o  = lsu_ready;
    assign bus.stall_pipe_o = stall_q;
    assign bus.rw_en_o      = rw_en_q;
    assign bus.waddr_o      = waddr_q;
    assign bus.wdata_o      = wdata_q;
endmodule
